// File: rtl/delay_and_sum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : delay_and_sum_pkg
// Description : Shared widths, types and delay clamp for the beamformer delay stage.
// Revision    : 1.0 - initial release
// ============================================================================
package delay_and_sum_pkg;

   localparam int SAMPLE_W  = 16;
   localparam int PROD_W    = 34;
   localparam int FRAC_BITS = 18;
   localparam int DEPTH     = 1024;
   localparam int ADDR_W    = 10;
   localparam int INT_W     = PROD_W - FRAC_BITS;

   typedef logic [SAMPLE_W-1:0] sample_t;
   typedef logic [PROD_W-1:0]   delay_prod_t;
   typedef logic [ADDR_W-1:0]   addr_t;

   typedef struct packed {
      logic  sat;
      addr_t delay;
   } clamp_t;

   localparam logic [INT_W-1:0] C_MAX_DELAY_INT = INT_W'(DEPTH - 1);
   localparam addr_t            C_MAX_DELAY     = ADDR_W'(DEPTH - 1);

   // Fractional bits are truncated; anything beyond the buffer depth clamps to DEPTH-1.
   function automatic clamp_t clamp_delay(input delay_prod_t prod);
      clamp_t           res;
      logic [INT_W-1:0] d_int;
      d_int = prod[PROD_W-1:FRAC_BITS];
      if (d_int > C_MAX_DELAY_INT) begin
         res.sat   = 1'b1;
         res.delay = C_MAX_DELAY;
      end else begin
         res.sat   = 1'b0;
         res.delay = d_int[ADDR_W-1:0];
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/delay_and_sum_sdp_ram.sv
`default_nettype none
// ============================================================================
// Module      : delay_and_sum_sdp_ram
// Description : DEPTH x SAMPLE_W simple dual-port RAM, sync write, async read.
// Revision    : 1.0 - initial release
// ============================================================================
module delay_and_sum_sdp_ram
   import delay_and_sum_pkg::*;
(
   input  logic    i_clk,
   input  logic    i_we,
   input  addr_t   i_waddr,
   input  sample_t i_wdata,
   input  addr_t   i_raddr,
   output sample_t o_rdata
);

   sample_t r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/delay_and_sum_delay_buffer.sv
`default_nettype none
// ============================================================================
// Module      : delay_and_sum_delay_buffer
// Description : Per-channel integer sample delay via circular buffer with valid/ready I/O.
// Revision    : 1.0 - initial release
// ============================================================================
module delay_and_sum_delay_buffer
   import delay_and_sum_pkg::*;
(
   input  logic                ap_clk,
   input  logic                ap_rst,
   input  logic [PROD_W-1:0]   delay_prod,
   input  logic                delay_load,
   input  logic [SAMPLE_W-1:0] in_sample,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [SAMPLE_W-1:0] out_sample,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                delay_sat
);

   localparam logic [ADDR_W:0] C_FILL_MAX = (ADDR_W + 1)'(DEPTH);

   addr_t           r_wr_ptr;
   logic [ADDR_W:0] r_fill_cnt;
   addr_t           r_delay_q;
   sample_t         r_out_sample;
   logic            r_out_valid;
   logic            r_delay_sat;

   logic    w_accept;
   addr_t   w_raddr;
   sample_t w_rdata;
   sample_t w_next;
   clamp_t  w_clamp;

   assign in_ready = !r_out_valid || out_ready;
   assign w_accept = in_valid && in_ready;
   assign w_raddr  = r_wr_ptr - r_delay_q;
   assign w_clamp  = clamp_delay(delay_prod);

   delay_and_sum_sdp_ram u_ram (
      .i_clk   (ap_clk),
      .i_we    (w_accept),
      .i_waddr (r_wr_ptr),
      .i_wdata (in_sample),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   // Zero delay bypasses the RAM so the read never depends on the same-cycle write.
   always_comb begin
      w_next = w_rdata;
      if (r_delay_q == '0) begin
         w_next = in_sample;
      end else if (r_fill_cnt < {1'b0, r_delay_q}) begin
         w_next = '0;
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_wr_ptr     <= '0;
         r_fill_cnt   <= '0;
         r_delay_q    <= '0;
         r_out_sample <= '0;
         r_out_valid  <= 1'b0;
         r_delay_sat  <= 1'b0;
      end else begin
         if (delay_load) begin
            r_delay_q <= w_clamp.delay;
            if (w_clamp.sat) begin
               r_delay_sat <= 1'b1;
            end
         end
         if (w_accept) begin
            r_wr_ptr     <= r_wr_ptr + 1'b1;
            r_out_sample <= w_next;
            r_out_valid  <= 1'b1;
            if (r_fill_cnt != C_FILL_MAX) begin
               r_fill_cnt <= r_fill_cnt + 1'b1;
            end
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_sample = r_out_sample;
   assign out_valid  = r_out_valid;
   assign delay_sat  = r_delay_sat;

endmodule
`default_nettype wire

// File: tb/tb_delay_and_sum_delay_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_delay_and_sum_delay_buffer
// Description : Scoreboard bench for the beamformer per-channel delay buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_and_sum_delay_buffer;

   logic        ap_clk = 1'b0;
   logic        ap_rst = 1'b0;
   logic [33:0] delay_prod = '0;
   logic        delay_load = 1'b0;
   logic [15:0] in_sample = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] out_sample;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        delay_sat;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] sb[$];
   logic [15:0] hist[$];
   int          m_delay = 0;

   delay_and_sum_delay_buffer dut (
      .ap_clk     (ap_clk),
      .ap_rst     (ap_rst),
      .delay_prod (delay_prod),
      .delay_load (delay_load),
      .in_sample  (in_sample),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_sample (out_sample),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .delay_sat  (delay_sat)
   );

   always #5 ap_clk = ~ap_clk;

   // One clock: observe the handshakes before the rising edge, update the model, advance.
   task automatic step(output bit acc);
      logic [15:0] exp;
      int          n;
      longint      d_int;
      #1;
      acc = in_valid && in_ready && !ap_rst;
      if (ap_rst) begin
         sb.delete();
         hist.delete();
         m_delay = 0;
      end else begin
         if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected_output got %h expected none", out_sample);
            end else begin
               exp = sb.pop_front();
               if (out_sample !== exp) begin
                  errors++;
                  $display("FAIL sb_out_sample got %h expected %h", out_sample, exp);
               end
            end
         end
         if (acc) begin
            hist.push_back(in_sample);
            n   = hist.size() - 1;
            exp = (n >= m_delay) ? hist[n - m_delay] : 16'h0000;
            sb.push_back(exp);
         end
         if (delay_load) begin
            d_int   = longint'(delay_prod >> 18);
            m_delay = (d_int > 1023) ? 1023 : int'(d_int);
         end
      end
      @(posedge ap_clk);
      @(negedge ap_clk);
   endtask

   task automatic do_reset();
      bit acc;
      ap_rst   = 1'b1;
      in_valid = 1'b0;
      step(acc);
      ap_rst   = 1'b0;
   endtask

   task automatic load(input logic [33:0] p);
      bit acc;
      delay_prod = p;
      delay_load = 1'b1;
      in_valid   = 1'b0;
      step(acc);
      delay_load = 1'b0;
   endtask

   task automatic send(input logic [15:0] x);
      bit acc;
      in_valid  = 1'b1;
      in_sample = x;
      out_ready = 1'b1;
      step(acc);
      in_valid   = 1'b0;
      delay_load = 1'b0;
   endtask

   task automatic drain(input string name);
      bit acc;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && (sb.size() != 0 || out_valid); i++) step(acc);
      checks++;
      if (sb.size() != 0 || out_valid) begin
         errors++;
         $display("FAIL %s_drain pending %0d out_valid %b expected 0 0", name, sb.size(), out_valid);
         sb.delete();
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (out_valid !== 1'b0 || out_sample !== 16'h0 || delay_sat !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_state got v=%b s=%h sat=%b rdy=%b expected 0 0000 0 1",
                  out_valid, out_sample, delay_sat, in_ready);
      end
      load(34'd3 << 18);
      for (int i = 1; i <= 8; i++) send(16'(i));
      drain("delay3");
      checks++;
      if (delay_sat !== 1'b0) begin
         errors++;
         $display("FAIL delay3_sat got %b expected 0", delay_sat);
      end
   endtask

   task automatic test_truncation();
      do_reset();
      load((34'd5 << 18) | 34'h3FFFF);
      for (int i = 0; i < 10; i++) send(16'(16'h100 + i));
      drain("trunc");
   endtask

   task automatic test_saturation();
      do_reset();
      load(34'd2000 << 18);
      checks++;
      if (delay_sat !== 1'b1) begin
         errors++;
         $display("FAIL sat_set got %b expected 1", delay_sat);
      end
      for (int i = 0; i < 1100; i++) send(16'(16'hA000 + i));
      drain("sat_wrap");
      checks++;
      if (delay_sat !== 1'b1) begin
         errors++;
         $display("FAIL sat_sticky got %b expected 1", delay_sat);
      end
      do_reset();
      checks++;
      if (delay_sat !== 1'b0) begin
         errors++;
         $display("FAIL sat_clear got %b expected 0", delay_sat);
      end
   endtask

   task automatic test_passthrough();
      bit   acc;
      logic exp_rdy;
      do_reset();
      load(34'd0);
      for (int i = 0; i < 400; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_sample = 16'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         #1;
         exp_rdy = !(out_valid && !out_ready);
         checks++;
         if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL pass_in_ready got %b expected %b", in_ready, exp_rdy);
         end
         step(acc);
      end
      drain("pass");
   endtask

   task automatic test_load_during_accept();
      do_reset();
      load(34'd2 << 18);
      for (int i = 0; i < 6; i++) send(16'(16'h50 + i));
      delay_prod = 34'd4 << 18;
      delay_load = 1'b1;
      send(16'h56);
      send(16'h57);
      send(16'h58);
      drain("load_same_cycle");
   endtask

   task automatic test_reset_midstream();
      bit acc;
      do_reset();
      load(34'd3 << 18);
      for (int i = 0; i < 50; i++) send(16'(16'h300 + i));
      ap_rst    = 1'b1;
      in_valid  = 1'b1;
      in_sample = 16'hDEAD;
      step(acc);
      ap_rst    = 1'b0;
      in_valid  = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL midrst_out_valid got %b expected 0", out_valid);
      end
      load(34'd3 << 18);
      for (int i = 0; i < 6; i++) send(16'(16'h400 + i));
      drain("midrst");
   endtask

   initial begin
      @(negedge ap_clk);
      test_reset();
      test_truncation();
      test_saturation();
      test_passthrough();
      test_load_during_accept();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
